// File: rtl/dict_stream_decoder.sv
// Dictionary stream decoder: rebuilds a 256-entry word table from LITERAL/INDEX/CLEAR
// tokens and emits one registered result beat per accepted token.
module dict_stream_decoder #(
   parameter int unsigned DATA_W = 80,
   parameter int unsigned IDX_W  = 8,
   parameter int unsigned DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_cmd,
   input  logic [DATA_W-1:0] in_data,
   input  logic [IDX_W-1:0]  in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_index,
   output logic [1:0]        out_resp,
   output logic [IDX_W:0]    fill_count,
   output logic [15:0]       err_count
);

   localparam logic [1:0] CmdClear   = 2'b00;
   localparam logic [1:0] CmdLiteral = 2'b01;
   localparam logic [1:0] CmdIndex   = 2'b10;

   localparam logic [1:0] RespCleared = 2'b00;
   localparam logic [1:0] RespStored  = 2'b01;
   localparam logic [1:0] RespDecoded = 2'b10;
   localparam logic [1:0] RespError   = 2'b11;

   localparam logic [IDX_W:0] FullCount = (IDX_W + 1)'(DEPTH);

   logic [DATA_W-1:0] dict_q [DEPTH];

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [IDX_W-1:0]  out_index_q, out_index_d;
   logic [1:0]        out_resp_q, out_resp_d;
   logic [IDX_W:0]    fill_q, fill_d;
   logic [15:0]       err_q, err_d;

   logic              accept;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_addr;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      out_resp_d  = out_resp_q;
      fill_d      = fill_q;
      err_d       = err_q;
      wr_en       = 1'b0;
      wr_addr     = fill_q[IDX_W-1:0];

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = '0;
         out_index_d = '0;
         out_resp_d  = RespError;
         case (in_cmd)
            CmdClear: begin
               fill_d     = '0;
               out_resp_d = RespCleared;
            end
            CmdLiteral: begin
               if (fill_q < FullCount) begin
                  wr_en       = 1'b1;
                  fill_d      = fill_q + (IDX_W + 1)'(1);
                  out_resp_d  = RespStored;
                  out_data_d  = in_data;
                  out_index_d = fill_q[IDX_W-1:0];
               end
            end
            CmdIndex: begin
               out_index_d = in_code;
               if ({1'b0, in_code} < fill_q) begin
                  out_resp_d = RespDecoded;
                  out_data_d = dict_q[in_code];
               end
            end
            default: ;
         endcase
         if (out_resp_d == RespError && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
         out_resp_q  <= '0;
         fill_q      <= '0;
         err_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         out_resp_q  <= out_resp_d;
         fill_q      <= fill_d;
         err_q       <= err_d;
      end
   end

   // Table storage needs no reset: entries at or above fill_count are never read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         dict_q[wr_addr] <= in_data;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_index  = out_index_q;
   assign out_resp   = out_resp_q;
   assign fill_count = fill_q;
   assign err_count  = err_q;

endmodule

// File: tb/tb_dict_stream_decoder.sv
// Scoreboard bench for dict_stream_decoder: the driver pushes hand-computed results on accept,
// a monitor pops and compares each consumed output beat.
module tb_dict_stream_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_cmd;
   logic [79:0] in_data;
   logic [7:0]  in_code;
   logic        out_valid;
   logic        out_ready;
   logic [79:0] out_data;
   logic [7:0]  out_index;
   logic [1:0]  out_resp;
   logic [8:0]  fill_count;
   logic [15:0] err_count;

   int checks = 0;
   int errors = 0;
   logic [89:0] exp_q [$];

   dict_stream_decoder dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
      .in_data(in_data), .in_code(in_code),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_resp(out_resp),
      .fill_count(fill_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   // Inputs only change #1 after posedge, so a negedge view shows what the next edge consumes.
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", {out_resp, out_index, out_data}, 96'h0);
         end else begin
            chk("beat", {out_resp, out_index, out_data}, exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [1:0] cmd, input logic [79:0] data, input logic [7:0] code,
                       input logic [1:0] er, input logic [79:0] ed, input logic [7:0] ei);
      bit ok = 0;
      in_valid = 1'b1;
      in_cmd   = cmd;
      in_data  = data;
      in_code  = code;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 96'd0, 96'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (ok) exp_q.push_back({er, ei, ed});
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         chk("drain_timeout", 96'(exp_q.size()), 96'd0);
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_cmd    = 2'b00;
      in_data   = '0;
      in_code   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid_ready", {out_valid, in_ready}, 96'b01);
      chk("rst_outputs", {out_resp, out_index, out_data}, 96'h0);
      chk("rst_counts", {fill_count, err_count}, 96'h0);
      @(posedge clk);
      #1 reset = 1'b1;

      // Three back-to-back literals, then good and out-of-range lookups.
      for (int i = 1; i <= 3; i++) send(2'b01, 80'(i), 8'd0, 2'b01, 80'(i), 8'(i - 1));
      drain();
      chk("fill_after_3", 96'(fill_count), 96'd3);
      send(2'b10, 80'h0, 8'd1, 2'b10, 80'h2, 8'd1);
      send(2'b10, 80'h0, 8'd3, 2'b11, 80'h0, 8'd3);
      drain();
      chk("err_after_idx3", 96'(err_count), 96'd1);

      // Fill to capacity, then overflow.
      send(2'b00, 80'h0, 8'd0, 2'b00, 80'h0, 8'd0);
      drain();
      chk("fill_after_clear", 96'(fill_count), 96'd0);
      for (int i = 0; i < 256; i++) send(2'b01, 80'(i), 8'd0, 2'b01, 80'(i), 8'(i));
      send(2'b01, 80'h1234, 8'd0, 2'b11, 80'h0, 8'd0);
      drain();
      chk("fill_full", 96'(fill_count), 96'd256);
      chk("err_after_overflow", 96'(err_count), 96'd2);
      send(2'b10, 80'h0, 8'd255, 2'b10, 80'd255, 8'd255);
      send(2'b10, 80'h0, 8'd0, 2'b10, 80'd0, 8'd0);
      drain();

      // Backpressure holds the beat and blocks the input.
      send(2'b00, 80'h0, 8'd0, 2'b00, 80'h0, 8'd0);
      drain();
      out_ready = 1'b0;
      send(2'b01, 80'hA, 8'd0, 2'b01, 80'hA, 8'd0);
      fork
         send(2'b10, 80'h0, 8'd0, 2'b10, 80'hA, 8'd0);
         begin
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               chk("bp_hold", {in_ready, out_valid, out_data}, {2'b01, 80'hA});
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // CLEAR empties the table; illegal command is an error.
      for (int i = 0; i < 4; i++) send(2'b01, 80'(16 + i), 8'd0, 2'b01, 80'(16 + i), 8'(i + 1));
      send(2'b00, 80'h0, 8'd0, 2'b00, 80'h0, 8'd0);
      drain();
      chk("fill_after_clear2", 96'(fill_count), 96'd0);
      send(2'b10, 80'h0, 8'd0, 2'b11, 80'h0, 8'd0);
      send(2'b01, 80'hB, 8'd0, 2'b01, 80'hB, 8'd0);
      send(2'b11, 80'h55, 8'd7, 2'b11, 80'h0, 8'd0);
      drain();
      chk("fill_after_b", 96'(fill_count), 96'd1);

      // Reset asserted with a beat pending.
      send(2'b00, 80'h0, 8'd0, 2'b00, 80'h0, 8'd0);
      for (int i = 0; i < 5; i++) send(2'b01, 80'(32 + i), 8'd0, 2'b01, 80'(32 + i), 8'(i));
      out_ready = 1'b0;
      @(negedge clk);
      chk("pre_rst_state", {out_valid, fill_count}, {1'b1, 9'd5});
      if (exp_q.size() != 0) void'(exp_q.pop_back());
      #2 reset = 1'b0;
      #1;
      chk("async_rst", {out_valid, fill_count, err_count}, 96'h0);
      repeat (2) @(posedge clk);
      #1;
      reset     = 1'b1;
      out_ready = 1'b1;
      send(2'b10, 80'h0, 8'd0, 2'b11, 80'h0, 8'd0);
      drain();
      chk("err_after_rst", 96'(err_count), 96'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dict_stream_decoder.md
Name: dict_stream_decoder

Overview:
- Receive-side counterpart of the dictionary compressor: rebuilds the 256-entry dictionary from an incoming token stream and emits the reconstructed 80-bit words.
- LITERAL tokens append to the next free slot, in the same order the compressor allocates indices. INDEX tokens are looked up in the rebuilt table.
- Uses the same 2-bit command/response encoding as the compressor, with valid/ready handshakes on both sides. Sits between the link receiver and the consumer of decompressed data.

Parameters:
DATA_W, 80, width of dictionary word
IDX_W, 8, width of index/code
DEPTH, 256, number of dictionary entries (must equal 2**IDX_W)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
in_valid  in  1  token present
in_ready  out  1  decoder can accept token this cycle
in_cmd  in  2  00 CLEAR, 01 LITERAL, 10 INDEX, 11 illegal
in_data  in  DATA_W  literal word (LITERAL only)
in_code  in  IDX_W  dictionary index (INDEX only)
out_valid  out  1  result beat present
out_ready  in  1  consumer accepts result
out_data  out  DATA_W  reconstructed word
out_index  out  IDX_W  slot written (LITERAL) or slot read (INDEX)
out_resp  out  2  00 cleared, 01 literal stored, 10 index decoded, 11 error
fill_count  out  IDX_W+1  valid entries, 0..DEPTH
err_count  out  16  saturating count of error responses

Behaviour:
- Reset (reset==0, async): out_valid=0; out_data, out_index, out_resp, fill_count and err_count all 0; in_ready=1. Table contents are don't-care; entries at or above fill_count are never readable.
- Accept: a token is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready, so the output register is a single stage with no combinational valid path.
- Latency: result is registered one cycle after accept. Throughput is one token per cycle while out_ready is held high.
- Out handshake: out_valid stays 1 and all out_* stay stable until out_ready. A new result is loaded in the same cycle the old one is consumed.
- Every accepted token produces exactly one result beat. This keeps the response stream aligned with the token stream.
- CLEAR: fill_count <= 0. Result is resp=00, data=0, index=0. err_count is unchanged.
- LITERAL, fill_count<DEPTH: table[fill_count] <= in_data; fill_count increments. Result is resp=01, data=in_data, index=old fill_count.
- LITERAL, fill_count==DEPTH: table and fill_count are unchanged. Result is resp=11, data=0, index=0.
- No duplicate check on LITERAL: the encoder never sends duplicates, so the decoder appends blindly.
- INDEX, in_code<fill_count: result is resp=10, data=table[in_code], index=in_code.
- INDEX, in_code>=fill_count: result is resp=11, data=0, index=in_code.
- in_cmd==11: result is resp=11, data=0, index=0.
- err_count increments on every accepted token yielding resp=11. It saturates at 16'hFFFF. Only reset clears it.
- Write-then-read: a LITERAL accepted in cycle N is visible to an INDEX accepted in cycle N+1. The table write happens at the accept edge and the read is in the next accept cycle, so no bypass path is needed.
- fill_count reaching DEPTH (256) needs the IDX_W+1 width; index arithmetic never wraps.
- Reset mid-stream: any pending result is dropped and out_valid is forced to 0 immediately. The first token after reset release sees fill_count=0.
- Backpressure: with out_ready=0 and out_valid=1, in_ready=0. No token is accepted and no state changes.

Test Plan:
- Reset, then LITERAL 80'h1, 80'h2, 80'h3 back-to-back with out_ready=1 -> resp 01 with index 0,1,2 on consecutive cycles; fill_count=3.
- After the above, INDEX 1, then INDEX 3 -> first result resp 10, data 80'h2, index 1; second result resp 11, data 0, index 3; err_count=1.
- 256 LITERALs of value i, then a 257th LITERAL -> last good result index 255, fill_count=256; 257th gives resp 11 and fill_count stays 256. INDEX 255 then returns data 255.
- LITERAL 80'hA, out_ready held 0 for 5 cycles while in_valid=1 with INDEX 0 -> in_ready=0 and out_data steady at 80'hA for 5 cycles. When out_ready=1, INDEX 0 is accepted and the next beat returns 80'hA with resp 10.
- CLEAR after 4 literals -> resp 00, fill_count=0; following INDEX 0 -> resp 11. Then LITERAL 80'hB gives index 0.
- Assert reset while out_valid=1 with fill_count=5 -> out_valid=0 and fill_count=0 asynchronously. After release, INDEX 0 -> resp 11 and err_count=1.
